id_hazard_scoreboard: RTL and testbench

ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

---
 rtl/id_hazard_scoreboard_pkg.sv | 19 +
 rtl/id_hazard_scoreboard_lat.sv | 31 +++
 rtl/id_hazard_scoreboard.sv | 94 +++++++++
 tb/tb_id_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared encodings and widths for the ID-stage hazard scoreboard.
// Producer classes arrive on issue_kind; only loads and mul/div are tracked.
package id_hazard_scoreboard_pkg;

   localparam int CNT_W  = 4;
   localparam int KIND_W = 2;

   typedef enum logic [KIND_W-1:0] {
      KIND_ALU  = 2'd0,
      KIND_LOAD = 2'd1,
      KIND_MD   = 2'd2,
      KIND_RSVD = 2'd3
   } issue_kind_e;

   function automatic logic is_tracked_kind(input issue_kind_e kind);
      return (kind == KIND_LOAD) || (kind == KIND_MD);
   endfunction

endpackage

// File: rtl/id_hazard_scoreboard_lat.sv
// hz_lat_counter: loadable down-counter that parks at zero.
// Priority: flush, then load/clear, then decrement.
module hz_lat_counter
   import id_hazard_scoreboard_pkg::*;
#(
   parameter int CW = CNT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          load,
   input  logic          clear,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (clear) begin
         cnt <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage RAW/structural hazard scoreboard: one latency timer per register plus
// one for the shared mul/div unit; stall is combinational from timer state.
module id_hazard_scoreboard
   import id_hazard_scoreboard_pkg::*;
#(
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 4,
   parameter int SCW      = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [1:0]      issue_kind,
   input  logic [AW-1:0]   issue_dst,
   input  logic [AW-1:0]   rs_addr,
   input  logic [AW-1:0]   rt_addr,
   input  logic            rs_used,
   input  logic            rt_used,
   input  logic            id_is_md,
   input  logic            flush,
   input  logic            irq,
   input  logic            kernel_if,
   input  logic            kernel_id,
   output logic            stall,
   output logic            pc_if_write,
   output logic [NREG-1:0] busy_vec,
   output logic [SCW-1:0]  stall_cnt
);

   issue_kind_e      kind;
   logic             issue_tracked;
   logic             issue_md;
   logic [CNT_W-1:0] lat_val;
   logic [CNT_W-1:0] cnt [NREG];
   logic [CNT_W-1:0] md_cnt;
   logic             raw_stall;
   logic             irq_bypass;

   assign kind          = issue_kind_e'(issue_kind);
   assign issue_tracked = issue_valid && is_tracked_kind(kind);
   assign issue_md      = issue_valid && (kind == KIND_MD);
   assign lat_val       = (kind == KIND_MD) ? CNT_W'(MD_LAT) : CNT_W'(LOAD_LAT);

   assign cnt[0]      = '0;
   assign busy_vec[0] = 1'b0;

   // ALU/reserved writes (and dst 0) clear the slot: the younger writer supersedes.
   for (genvar i = 1; i < NREG; i++) begin : g_reg
      logic dst_hit;
      assign dst_hit = issue_valid && (issue_dst == AW'(i));

      hz_lat_counter #(.CW(CNT_W)) u_cnt (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .load     (dst_hit && issue_tracked),
         .clear    (dst_hit && !issue_tracked),
         .load_val (lat_val),
         .cnt      (cnt[i])
      );

      assign busy_vec[i] = (cnt[i] != '0);
   end

   hz_lat_counter #(.CW(CNT_W)) u_md_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load     (issue_md),
      .clear    (1'b0),
      .load_val (CNT_W'(MD_LAT)),
      .cnt      (md_cnt)
   );

   assign raw_stall = (rs_used  && (cnt[rs_addr] != '0)) ||
                      (rt_used  && (cnt[rt_addr] != '0)) ||
                      (id_is_md && (md_cnt != '0));

   // User-mode interrupt entry must not be held off by a hazard on in-flight user code.
   assign irq_bypass  = irq && !kernel_if && !kernel_id;
   assign stall       = raw_stall && !irq_bypass;
   assign pc_if_write = !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {SCW{1'b1}})) begin
         stall_cnt <= stall_cnt + SCW'(1);
      end
   end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard; a second instance with a 2-bit
// stall counter shares the stimulus to exercise saturation.
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [1:0]  issue_kind;
  logic [4:0]  issue_dst;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_used, rt_used, id_is_md, flush, irq, kernel_if, kernel_id;
  logic        stall, pc_if_write;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;
  logic        stall2, pcw2;
  logic [31:0] busy2;
  logic [1:0]  sc2;

  int total = 0;
  int bad = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  id_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_kind(issue_kind),
    .issue_dst(issue_dst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used),
    .rt_used(rt_used), .id_is_md(id_is_md), .flush(flush), .irq(irq),
    .kernel_if(kernel_if), .kernel_id(kernel_id), .stall(stall),
    .pc_if_write(pc_if_write), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  id_hazard_scoreboard #(.SCW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_kind(issue_kind),
    .issue_dst(issue_dst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used),
    .rt_used(rt_used), .id_is_md(id_is_md), .flush(flush), .irq(irq),
    .kernel_if(kernel_if), .kernel_id(kernel_id), .stall(stall2),
    .pc_if_write(pcw2), .busy_vec(busy2), .stall_cnt(sc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_kind = 0; issue_dst = 0;
    rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
    id_is_md = 0; flush = 0; irq = 0; kernel_if = 0; kernel_id = 0;
  endtask

  task automatic issue(input logic [1:0] k, input logic [4:0] d);
    issue_valid = 1; issue_kind = k; issue_dst = d;
    step();
    issue_valid = 0; issue_kind = 0; issue_dst = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL reset_pcw got=%0b exp=1", pc_if_write); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy got=%08h exp=00000000", busy_vec); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_scnt got=%0d exp=0", stall_cnt); end
    #5;
    rst_n = 1;
    step();
  endtask

  task automatic test_load_use();
    issue(2'd1, 5'd5);
    rs_addr = 5; rs_used = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall got=%0b exp=1", stall); end
    total++; if (pc_if_write !== 1'b0) begin bad++; $display("FAIL load_pcw got=%0b exp=0", pc_if_write); end
    total++; if (busy_vec !== 32'h0000_0020) begin bad++; $display("FAIL load_busy got=%08h exp=00000020", busy_vec); end
    step();
    exp_sc = 1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_release got=%0b exp=0", stall); end
    total++; if (stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL load_scnt got=%0d exp=%0d", stall_cnt, exp_sc); end
    rs_used = 0;
  endtask

  task automatic test_md();
    issue(2'd2, 5'd8);
    rt_addr = 8; rt_used = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL md_stall cyc=%0d got=%0b exp=1", k, stall); end
      step();
    end
    exp_sc += 4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_release got=%0b exp=0", stall); end
    total++; if (stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL md_scnt got=%0d exp=%0d", stall_cnt, exp_sc); end
    rt_used = 0;
    issue(2'd2, 5'd8);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_unused got=%0b exp=0", stall); end
    total++; if (busy_vec !== 32'h0000_0100) begin bad++; $display("FAIL md_busy got=%08h exp=00000100", busy_vec); end
    id_is_md = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL md_unit_busy got=%0b exp=1", stall); end
    id_is_md = 0;
    for (int k = 0; k < 4; k++) step();
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL md_drain got=%08h exp=00000000", busy_vec); end
  endtask

  task automatic test_alu_supersede();
    issue(2'd1, 5'd3);
    issue(2'd0, 5'd3);
    rs_addr = 3; rs_used = 1;
    #1;
    total++; if (busy_vec[3] !== 1'b0) begin bad++; $display("FAIL alu_busy got=%0b exp=0", busy_vec[3]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b exp=0", stall); end
    rs_used = 0;
    issue(2'd2, 5'd3);
    issue(2'd3, 5'd3);
    rs_used = 1;
    #1;
    total++; if (busy_vec[3] !== 1'b0) begin bad++; $display("FAIL rsvd_busy got=%0b exp=0", busy_vec[3]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rsvd_stall got=%0b exp=0", stall); end
    rs_used = 0;
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_irq();
    issue(2'd1, 5'd5);
    rs_addr = 5; rs_used = 1; irq = 1; kernel_if = 0; kernel_id = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL irq_bypass got=%0b exp=0", stall); end
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL irq_pcw got=%0b exp=1", pc_if_write); end
    kernel_id = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL irq_kernel got=%0b exp=1", stall); end
    step();
    exp_sc += 1;
    irq = 0; kernel_id = 0; rs_used = 0;
    total++; if (stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL irq_scnt got=%0d exp=%0d", stall_cnt, exp_sc); end
  endtask

  task automatic test_flush();
    issue(2'd2, 5'd9);
    step();
    total++; if (busy_vec !== 32'h0000_0200) begin bad++; $display("FAIL flush_pre got=%08h exp=00000200", busy_vec); end
    flush = 1;
    issue(2'd1, 5'd9);
    flush = 0;
    id_is_md = 1; rs_addr = 9; rs_used = 1;
    #1;
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL flush_busy got=%08h exp=00000000", busy_vec); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    id_is_md = 0; rs_used = 0;
  endtask

  task automatic test_r0();
    issue(2'd1, 5'd0);
    rs_addr = 0; rs_used = 1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%0b exp=0", stall); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL r0_busy got=%08h exp=00000000", busy_vec); end
    rs_used = 0;
  endtask

  task automatic test_reload();
    issue(2'd2, 5'd8);
    step();
    issue(2'd1, 5'd8);
    rt_addr = 8; rt_used = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reload_stall got=%0b exp=1", stall); end
    step();
    exp_sc += 1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reload_release got=%0b exp=0", stall); end
    rt_used = 0;
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_reset_mid();
    issue(2'd2, 5'd8);
    rt_addr = 8; rt_used = 1;
    step();
    exp_sc += 1;
    total++; if (stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL mid_scnt_pre got=%0d exp=%0d", stall_cnt, exp_sc); end
    rst_n = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall got=%0b exp=0", stall); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL mid_scnt got=%0d exp=0", stall_cnt); end
    total++; if (sc2 !== 2'd0) begin bad++; $display("FAIL mid_scnt2 got=%0d exp=0", sc2); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL mid_busy got=%08h exp=00000000", busy_vec); end
    rt_used = 0;
    #2;
    rst_n = 1;
    step();
  endtask

  task automatic test_saturate();
    issue(2'd2, 5'd8);
    rt_addr = 8; rt_used = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (stall_cnt !== 32'(k)) begin bad++; $display("FAIL sat_main k=%0d got=%0d exp=%0d", k, stall_cnt, k); end
      total++; if (sc2 !== ((k > 3) ? 2'd3 : 2'(k))) begin bad++; $display("FAIL sat_scw2 k=%0d got=%0d exp=%0d", k, sc2, (k > 3) ? 3 : k); end
    end
    rt_used = 0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md();
    test_alu_supersede();
    test_irq();
    test_flush();
    test_r0();
    test_reload();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
